// File: rtl/wait_rx_buffer_if.sv
// ---------------------------------------------------------------------------
// wait_rx_buffer_if
//   Byte-stream handshake bundle around wait_rx_buffer.
//   Sender side  : din, din_vld in; s_wait back to the sender.
//   Drain side   : dout, dout_vld out; dout_rdy from downstream.
//   Modports:
//     slave  - the buffer (receives din, drives s_wait and dout)
//     master - the environment (sender plus downstream consumer)
// ---------------------------------------------------------------------------
interface wait_rx_buffer_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din;
    logic          din_vld;
    logic          s_wait;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;

    modport slave (
        input  din,
        input  din_vld,
        input  dout_rdy,
        output s_wait,
        output dout,
        output dout_vld
    );

    modport master (
        output din,
        output din_vld,
        output dout_rdy,
        input  s_wait,
        input  dout,
        input  dout_vld
    );
endinterface

// File: rtl/wait_rx_buffer.sv
// ---------------------------------------------------------------------------
// wait_rx_buffer
//   Receiving end of the "send when not waiting" byte stream. Incoming bytes
//   are captured into a first-word-fall-through FIFO; s_wait is a registered
//   backpressure flag that rises while SKID or fewer entries remain free, so a
//   sender reacting one cycle late still lands its byte in the margin.
//
//   Ports:
//     clk     - clock, all state on posedge
//     rstn    - asynchronous active-low reset
//     clr     - synchronous flush (FIFO, rx_cnt, ovf), wins over push/pop
//     bus     - wait_rx_buffer_if.slave: din/din_vld/s_wait, dout/dout_vld/dout_rdy
//     count   - current FIFO occupancy
//     rx_cnt  - bytes accepted since reset/clr, wraps at 16 bits
//     ovf     - sticky: a byte arrived while full with no pop, and was dropped
// ---------------------------------------------------------------------------
module wait_rx_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int SKID  = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    wait_rx_buffer_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                rx_cnt,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [15:0]   rx_cnt_q;
    logic          ovf_q;
    logic          s_wait_q;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic [CW-1:0] count_next;
    logic [CW-1:0] free_next;
    logic          s_wait_next;

    // Handshake decode: a pop at full frees the slot the concurrent push uses.
    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        pop         = !empty && bus.dout_rdy;
        push        = bus.din_vld && (!full || pop);
        drop        = bus.din_vld && full && !pop;
        count_next  = count_q + CW'(push) - CW'(pop);
        free_next   = CW'(DEPTH) - count_next;
        s_wait_next = (free_next <= CW'(SKID));
    end

    // Storage: data only, no reset; pointers gate what is visible.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Control state: pointers, occupancy, counters and backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            s_wait_q <= 1'b1;  // hold the sender off while in reset
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            rx_cnt_q <= '0;
            ovf_q    <= 1'b0;
            s_wait_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                rx_cnt_q <= rx_cnt_q + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            count_q  <= count_next;
            // Registered from post-update occupancy so it tracks this edge.
            s_wait_q <= s_wait_next;
        end
    end

    assign bus.dout     = mem[rd_ptr];
    assign bus.dout_vld = !empty;
    assign bus.s_wait   = s_wait_q;
    assign count        = count_q;
    assign rx_cnt       = rx_cnt_q;
    assign ovf          = ovf_q;
endmodule

// File: tb/tb_wait_rx_buffer.sv
module tb_wait_rx_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int SKID  = 2;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic [4:0]  count;
    logic [15:0] rx_cnt;
    logic        ovf;

    wait_rx_buffer_if #(.DW(DW)) bus ();

    wait_rx_buffer #(.DW(DW), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (clr),
        .bus    (bus),
        .count  (count),
        .rx_cnt (rx_cnt),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of bytes plus the visible counters.
    logic [7:0]  q[$];
    logic [15:0] m_rx;
    logic        m_ovf;
    logic        m_wait;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_rx   = '0;
        m_ovf  = 1'b0;
        m_wait = 1'b1;
    endtask

    task automatic model_step();
        bit do_pop, do_push;
        if (clr) begin
            q.delete();
            m_rx   = '0;
            m_ovf  = 1'b0;
            m_wait = 1'b0;
        end else begin
            do_pop  = (q.size() > 0) && bus.dout_rdy;
            do_push = bus.din_vld && ((q.size() < DEPTH) || do_pop);
            if (bus.din_vld && q.size() == DEPTH && !do_pop) m_ovf = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(bus.din);
                m_rx = m_rx + 16'd1;
            end
            m_wait = ((DEPTH - q.size()) <= SKID);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("dout_vld", 32'(bus.dout_vld), 32'(q.size() != 0));
        if (q.size() != 0) chk("dout", 32'(bus.dout), 32'(q[0]));
        chk("s_wait", 32'(bus.s_wait), 32'(m_wait));
        chk("rx_cnt", 32'(rx_cnt), 32'(m_rx));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    // Inputs are held from the previous negedge; model and DUT both see them
    // at the posedge, outputs are compared at the following negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        bus.din_vld  = 1'b0;
        bus.din      = '0;
        bus.dout_rdy = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        bus.din_vld  = 1'b0;
        bus.dout_rdy = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 64) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 32'(q.size()), 32'd0);
        bus.dout_rdy = 1'b0;
    endtask

    initial begin
        bit saw, stop;
        int sent;

        idle_inputs();
        rstn = 1'b0;
        model_reset();

        // Reset and release
        repeat (2) begin
            @(negedge clk);
            chk("rst_s_wait", 32'(bus.s_wait), 32'd1);
            chk("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
        end
        rstn = 1'b1;
        cycle();
        chk("rel_s_wait", 32'(bus.s_wait), 32'd0);

        // Streaming with no stall
        bus.dout_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.din_vld = 1'b1;
            bus.din     = 8'(i);
            cycle();
            chk("stream_count_le1", 32'(count <= 5'd1), 32'd1);
        end
        bus.din_vld = 1'b0;
        cycle();
        chk("stream_rx_cnt", 32'(rx_cnt), 32'd16);
        chk("stream_empty", 32'(count), 32'd0);

        // Backpressure with a sender that reacts one cycle late
        bus.dout_rdy = 1'b0;
        saw  = 1'b0;
        stop = 1'b0;
        sent = 0;
        while (!stop && sent < 20) begin
            bus.din_vld = 1'b1;
            bus.din     = 8'($urandom);
            cycle();
            sent++;
            if (saw) stop = 1'b1;
            else if (bus.s_wait) saw = 1'b1;
        end
        bus.din_vld = 1'b0;
        chk("bp_sent", 32'(sent), 32'd15);
        chk("bp_count", 32'(count), 32'd15);
        chk("bp_ovf", 32'(ovf), 32'd0);
        drain("bp");

        // Overflow: 17 bytes into a stalled FIFO, rx_cnt started fresh by clr
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.din_vld = 1'b1;
            bus.din     = 8'($urandom);
            cycle();
        end
        bus.din_vld = 1'b0;
        cycle();
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_rx_cnt", 32'(rx_cnt), 32'd16);

        // Simultaneous push and pop while full, across pointer wrap
        bus.dout_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.din_vld = 1'b1;
            bus.din     = 8'($urandom);
            cycle();
            chk("full_pp_count", 32'(count), 32'd16);
        end
        chk("full_pp_ovf", 32'(ovf), 32'd1);
        drain("full_pp");

        // clr with a concurrent byte
        for (int i = 0; i < 5; i++) begin
            bus.din_vld = 1'b1;
            bus.din     = 8'($urandom);
            cycle();
        end
        chk("clr_pre_count", 32'(count), 32'd5);
        clr         = 1'b1;
        bus.din_vld = 1'b1;
        bus.din     = 8'hA5;
        cycle();
        clr         = 1'b0;
        bus.din_vld = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_rx_cnt", 32'(rx_cnt), 32'd0);
        chk("clr_ovf", 32'(ovf), 32'd0);
        cycle();
        chk("clr_not_stored", 32'(bus.dout_vld), 32'd0);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            bus.din_vld  = ($urandom_range(0, 3) != 0);
            bus.din      = 8'($urandom);
            bus.dout_rdy = ($urandom_range(0, 2) == 0);
            clr          = ($urandom_range(0, 59) == 0);
            cycle();
        end
        clr = 1'b0;

        // Mid-stream asynchronous reset
        bus.din_vld  = 1'b1;
        bus.dout_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.din = 8'($urandom);
            cycle();
        end
        bus.din_vld = 1'b0;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("arst_s_wait", 32'(bus.s_wait), 32'd1);
        chk("arst_dout_vld", 32'(bus.dout_vld), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_rx_cnt", 32'(rx_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cycle();
        chk("arst_rel_s_wait", 32'(bus.s_wait), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
